// File: rtl/service_3_stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// service_3_stopwatch_pkg
//   Shared definitions for the service-3 stopwatch.
//   - `S0..`S3 : state codes as text macros. They are visible to every file
//                compiled after this one, including benches.
//   - state_t  : typed view of the same codes, used by the RTL.
//   - DIGIT_MAX: last value of one BCD digit.
//   - bcd_pair_to_int: converts two BCD digits into a 0..99 integer, used for
//                the debug views.
//   No ports: this is a package.
// -----------------------------------------------------------------------------
`ifndef SERVICE_DEFS_VH
`define SERVICE_DEFS_VH
`define S0 2'd0
`define S1 2'd1
`define S2 2'd2
`define S3 2'd3
`endif

package service_3_stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = `S0,
      ST_READY = `S1,
      ST_RUN   = `S2,
      ST_PAUSE = `S3
   } state_t;

   localparam logic [3:0] DIGIT_MAX = 4'd9;

   function automatic logic [6:0] bcd_pair_to_int(input logic [3:0] tens,
                                                  input logic [3:0] units);
      return ({3'b000, tens} * 7'd10) + {3'b000, units};
   endfunction

endpackage

// File: rtl/service_3_stopwatch_if.sv
// -----------------------------------------------------------------------------
// service_3_stopwatch_if
//   Connects the front panel to the stopwatch service.
//   SPDT3      : service enable switch (level, 1 = active)
//   push_m     : debounced start/pause button
//   segments   : BCD {sec_tens, sec_units, tenths, hundredths}
//   finish3    : service-exited flag (level)
//   seconds    : debug integer view of the seconds, 0..99
//   hundredths : debug integer view of the hundredths, 0..99
//   master modport: panel/selector side. slave modport: the stopwatch.
// -----------------------------------------------------------------------------
interface service_3_stopwatch_if;
   logic        SPDT3;
   logic        push_m;
   logic [15:0] segments;
   logic        finish3;
   logic [6:0]  seconds;
   logic [6:0]  hundredths;

   modport master (
      output SPDT3, push_m,
      input  segments, finish3, seconds, hundredths
   );

   modport slave (
      input  SPDT3, push_m,
      output segments, finish3, seconds, hundredths
   );
endinterface

// File: rtl/service_3_stopwatch_bcd_digit.sv
// -----------------------------------------------------------------------------
// sw3_bcd_digit
//   One mod-10 counter stage of the stopwatch cascade.
//   clk       : system clock
//   resetn    : synchronous active-low reset
//   clr       : synchronous clear to 0; has priority over inc
//   inc       : advance by one
//   carry_out : high when inc arrives while the digit is at 9. Feeds the next
//               stage. Combinational.
//   q[3:0]    : current digit, always in 0..9
// -----------------------------------------------------------------------------
module sw3_bcd_digit
   import service_3_stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       clr,
   input  logic       inc,
   output logic       carry_out,
   output logic [3:0] q
);

   assign carry_out = inc && (q == DIGIT_MAX);

   // NOTE: sequential state is assigned with <= so every register samples
   // pre-edge values; blocking '=' here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!resetn || clr) begin
         q <= '0;
      end else if (inc) begin
         q <= (q == DIGIT_MAX) ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/service_3_stopwatch.sv
// -----------------------------------------------------------------------------
// service_3_stopwatch
//   Service 3 of the multi-service front panel. It is a 00.00-99.99 s
//   stopwatch with 10 ms resolution. A push_m press cycles
//   start -> pause -> resume. Dropping SPDT3 exits the service and raises
//   finish3.
//
//   Parameters
//     CLK_FREQ_HZ : system clock frequency
//     TICK_HZ     : count rate (100 = hundredths)
//     TICK_DIV    : derived as CLK_FREQ_HZ / TICK_HZ, in clock cycles per tick
//
//   Ports
//     clk    : system clock, single domain
//     resetn : synchronous active-low reset
//     panel  : service_3_stopwatch_if.slave
//              (SPDT3, push_m in; segments, finish3, seconds, hundredths out)
//
//   Configuration
//     SW3_SATURATE_EN defined : the count stops at 99.99. The FSM stays in
//                               RUN and a press still pauses.
//     SW3_SATURATE_EN undefined (default) : 99.99 wraps to 00.00 and counting
//                               continues.
// -----------------------------------------------------------------------------
module service_3_stopwatch
   import service_3_stopwatch_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 100
)(
   input  logic                  clk,
   input  logic                  resetn,
   service_3_stopwatch_if.slave  panel
);

   localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   state_t            stopwatch_state;
   state_t            state_next;

   logic              push_q;
   logic              press;

   logic [DIV_W-1:0]  div_q;
   logic              div_run;
   logic              tick;

   logic              clr_cnt;
   logic              exit_svc;
   logic              cnt_inc;

   logic [3:0]        d_hund;
   logic [3:0]        d_tenth;
   logic [3:0]        d_sec_u;
   logic [3:0]        d_sec_t;
   logic              c_hund;
   logic              c_tenth;
   logic              c_sec_u;
   logic              unused_rollover;

   // ---------------------------------------------------------------------------
   // Press edge detector. It tracks in every state, so a button already held
   // when entering a state does not count as a fresh press.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         push_q <= 1'b0;
      end else begin
         push_q <= panel.push_m;
      end
   end

   assign press = panel.push_m & ~push_q;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stopwatch_state <= ST_IDLE;
      end else begin
         stopwatch_state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state. The switch dropping out of any active state wins over a
   // press in the same cycle.
   // ---------------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default first;
   // a path that leaves one unassigned infers a latch.
   always_comb begin
      state_next = stopwatch_state;
      unique case (stopwatch_state)
         ST_IDLE: begin
            if (panel.SPDT3) state_next = ST_READY;
         end
         ST_READY: begin
            if (!panel.SPDT3) state_next = ST_IDLE;
            else if (press)   state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!panel.SPDT3) state_next = ST_IDLE;
            else if (press)   state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (!panel.SPDT3) state_next = ST_IDLE;
            else if (press)   state_next = ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. The counters and the divider are held clear in IDLE and are
   // cleared on the exit edge. The divider runs only while RUN is held.
   // In PAUSE it keeps its partial count, so a resume continues from the
   // exact sub-tick phase it was paused at.
   // ---------------------------------------------------------------------------
   always_comb begin
      clr_cnt  = 1'b0;
      exit_svc = 1'b0;
      div_run  = 1'b0;
      if (stopwatch_state == ST_IDLE) begin
         clr_cnt = 1'b1;
      end else if (!panel.SPDT3) begin
         clr_cnt  = 1'b1;
         exit_svc = 1'b1;
      end else if (stopwatch_state == ST_RUN) begin
         div_run = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Tick divider: counts 0..TICK_DIV-1. The tick is issued on the edge that
   // wraps it back to 0, so the first hundredth lands exactly TICK_DIV cycles
   // after the start press.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn || clr_cnt) begin
         div_q <= '0;
      end else if (div_run) begin
         div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
   end

   assign tick = div_run && (div_q == DIV_LAST);

`ifdef SW3_SATURATE_EN
   logic at_max;
   assign at_max  = (d_sec_t == DIGIT_MAX) && (d_sec_u == DIGIT_MAX) &&
                    (d_tenth == DIGIT_MAX) && (d_hund  == DIGIT_MAX);
   assign cnt_inc = tick && !at_max;
`else
   assign cnt_inc = tick;
`endif

   // ---------------------------------------------------------------------------
   // BCD cascade: hundredths -> tenths -> sec_units -> sec_tens.
   // The carry out of the top digit marks the 99.99 -> 00.00 wrap. Nothing
   // consumes it.
   // ---------------------------------------------------------------------------
   sw3_bcd_digit u_hund (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (clr_cnt),
      .inc       (cnt_inc),
      .carry_out (c_hund),
      .q         (d_hund)
   );

   sw3_bcd_digit u_tenth (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (clr_cnt),
      .inc       (c_hund),
      .carry_out (c_tenth),
      .q         (d_tenth)
   );

   sw3_bcd_digit u_sec_u (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (clr_cnt),
      .inc       (c_tenth),
      .carry_out (c_sec_u),
      .q         (d_sec_u)
   );

   sw3_bcd_digit u_sec_t (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (clr_cnt),
      .inc       (c_sec_u),
      .carry_out (unused_rollover),
      .q         (d_sec_t)
   );

   // ---------------------------------------------------------------------------
   // Display register: one cycle behind the digit registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         panel.segments <= 16'h0000;
      end else begin
         panel.segments <= {d_sec_t, d_sec_u, d_tenth, d_hund};
      end
   end

   // ---------------------------------------------------------------------------
   // finish3: set on the exit edge. It holds until the switch is seen high
   // again in IDLE. Reset clears it and never sets it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         panel.finish3 <= 1'b0;
      end else if (exit_svc) begin
         panel.finish3 <= 1'b1;
      end else if ((stopwatch_state == ST_IDLE) && panel.SPDT3) begin
         panel.finish3 <= 1'b0;
      end
   end

   // Debug integer views, taken straight from the digit registers.
   assign panel.seconds    = bcd_pair_to_int(d_sec_t, d_sec_u);
   assign panel.hundredths = bcd_pair_to_int(d_tenth, d_hund);

endmodule

// File: tb/tb_service_3_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_service_3_stopwatch
//   Directed stimulus for service_3_stopwatch with TICK_DIV = 3.
//   Each step queues its hand-computed expectations. A monitor on the falling
//   clock edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_service_3_stopwatch;

   localparam int TD = 3;

   typedef enum {K_SEG, K_FIN, K_STATE, K_SEC, K_HUND} kind_t;

   typedef struct {
      string       name;
      kind_t       kind;
      logic [15:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   service_3_stopwatch_if panel();

   service_3_stopwatch #(
      .CLK_FREQ_HZ (TD * 100),
      .TICK_HZ     (100)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .panel  (panel)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] observe(input kind_t k);
      case (k)
         K_SEG:   return panel.segments;
         K_FIN:   return {15'b0, panel.finish3};
         K_STATE: return {14'b0, dut.stopwatch_state};
         K_SEC:   return {9'b0, panel.seconds};
         default: return {9'b0, panel.hundredths};
      endcase
   endfunction

   task automatic expect_v(input string name, input kind_t k, input logic [15:0] v);
      exp_t e;
      e.name = name;
      e.kind = k;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_push();
      panel.push_m = 1'b1;
      cycles(1);
      panel.push_m = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         check(e.name, observe(e.kind), e.exp);
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      resetn       = 1'b0;
      panel.SPDT3  = 1'b0;
      panel.push_m = 1'b0;

      // Reset state
      cycles(2);
      expect_v("rst_seg",   K_SEG,   16'h0000);
      expect_v("rst_fin",   K_FIN,   16'd0);
      expect_v("rst_state", K_STATE, 16'(`S0));
      expect_v("rst_hund",  K_HUND,  16'd0);
      expect_v("rst_sec",   K_SEC,   16'd0);
      resetn = 1'b1;
      cycles(1);
      expect_v("idle_no_switch", K_STATE, 16'(`S0));
      expect_v("idle_fin",       K_FIN,   16'd0);

      // Enable -> READY
      panel.SPDT3 = 1'b1;
      cycles(2);
      expect_v("ready_state", K_STATE, 16'(`S1));
      expect_v("ready_seg",   K_SEG,   16'h0000);

      // Start. Press edge P. Tick k lands on edge P + k*TD.
      pulse_push();
      expect_v("start_state", K_STATE, 16'(`S2));
      cycles(164 * TD - 1);
      expect_v("run_hund_163", K_HUND, 16'd63);
      expect_v("run_sec_163",  K_SEC,  16'd1);
      cycles(1);
      expect_v("run_hund_164", K_HUND, 16'd64);
      expect_v("run_seg_lag",  K_SEG,  16'h0163);
      cycles(1);
      expect_v("run_seg_164",  K_SEG,  16'h0164);

      // Pause. The divider is at 1 here, so no tick occurs on the pause edge.
      pulse_push();
      expect_v("pause_state", K_STATE, 16'(`S3));
      expect_v("pause_hund",  K_HUND,  16'd64);
      cycles(10 * TD);
      expect_v("pause_frozen_seg",   K_SEG,   16'h0164);
      expect_v("pause_frozen_state", K_STATE, 16'(`S3));

      // Resume. The divider is frozen at 2 = TD-1, so the next edge ticks.
      pulse_push();
      expect_v("resume_state", K_STATE, 16'(`S2));
      expect_v("resume_hund",  K_HUND,  16'd64);
      cycles(1);
      expect_v("resume_tick_hund", K_HUND, 16'd65);
      expect_v("resume_tick_seg",  K_SEG,  16'h0164);
      cycles(1);
      expect_v("resume_seg_165",   K_SEG,  16'h0165);

      // Pause again, then exit from PAUSE
      pulse_push();
      expect_v("pause2_state", K_STATE, 16'(`S3));
      expect_v("pause2_hund",  K_HUND,  16'd65);
      panel.SPDT3 = 1'b0;
      cycles(1);
      expect_v("exit_state",   K_STATE, 16'(`S0));
      expect_v("exit_fin",     K_FIN,   16'd1);
      expect_v("exit_hund",    K_HUND,  16'd0);
      expect_v("exit_seg_lag", K_SEG,   16'h0165);
      cycles(1);
      expect_v("exit_seg",     K_SEG,   16'h0000);
      expect_v("exit_fin_hold", K_FIN,  16'd1);

      // A press in IDLE is ignored
      pulse_push();
      expect_v("idle_press_state", K_STATE, 16'(`S0));
      expect_v("idle_press_fin",   K_FIN,   16'd1);

      // Re-enable clears finish3
      panel.SPDT3 = 1'b1;
      cycles(1);
      expect_v("reenter_state", K_STATE, 16'(`S1));
      expect_v("reenter_fin",   K_FIN,   16'd0);

      // An exit in READY wins over a simultaneous press
      panel.push_m = 1'b1;
      panel.SPDT3  = 1'b0;
      cycles(1);
      panel.push_m = 1'b0;
      expect_v("exit_over_press_state", K_STATE, 16'(`S0));
      expect_v("exit_over_press_fin",   K_FIN,   16'd1);
      panel.SPDT3 = 1'b1;
      cycles(1);
      expect_v("reenter2_state", K_STATE, 16'(`S1));
      expect_v("reenter2_fin",   K_FIN,   16'd0);

      // Run to 99.99, then one more tick
      pulse_push();
      expect_v("run2_state", K_STATE, 16'(`S2));
      cycles(9999 * TD);
      expect_v("max_sec",  K_SEC,  16'd99);
      expect_v("max_hund", K_HUND, 16'd99);
      cycles(1);
      expect_v("max_seg",  K_SEG,  16'h9999);
      cycles(TD - 1);
`ifdef SW3_SATURATE_EN
      expect_v("over_sec",  K_SEC,  16'd99);
      expect_v("over_hund", K_HUND, 16'd99);
      cycles(1);
      expect_v("over_seg",  K_SEG,  16'h9999);
      expect_v("over_state", K_STATE, 16'(`S2));
      cycles(TD);
      expect_v("over2_seg", K_SEG,  16'h9999);
`else
      expect_v("over_sec",  K_SEC,  16'd0);
      expect_v("over_hund", K_HUND, 16'd0);
      cycles(1);
      expect_v("over_seg",  K_SEG,  16'h0000);
      expect_v("over_state", K_STATE, 16'(`S2));
      cycles(TD);
      expect_v("over2_seg", K_SEG,  16'h0001);
`endif
      pulse_push();
      expect_v("final_pause_state", K_STATE, 16'(`S3));

      // Let the monitor drain, then confirm the queue is empty
      @(negedge clk);
      #1;
      check("scoreboard_drained", 16'(sb.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
